bfs_hop_engine: RTL and testbench

Parametrised breadth-first hop-count engine for the train-tour lab family, successor to the fixed 16-station single-query block. It loads an undirected station graph from an edge stream and retains it. It then answers any number of source/destination queries against that graph, each with the minimum hop count and a reachability flag. Search is level-synchronous over bitmasks: one BFS level per cycle, with no queue.

---
 rtl/bfs_hop_engine.sv | 167 ++++++++++++++++
 tb/tb_bfs_hop_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bfs_hop_engine.sv
// bfs_hop_engine
//   Level-synchronous breadth-first hop-count engine over a retained,
//   undirected station graph. An edge stream loads the adjacency matrix.
//   Queries then return the minimum hop count and a reachability flag.
//   The search advances one BFS level per cycle using frontier/visited
//   bitmasks, so no queue is needed.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   edge-stream beat valid
//   in_src     edge endpoint A
//   in_dst     edge endpoint B
//   q_valid    query request
//   q_src      query source station
//   q_dst      query destination station
//   q_ready    query accepted when q_valid && q_ready (combinational)
//   out_valid  one-cycle result strobe (registered)
//   cost       hop count, 0 unless found (registered)
//   found      destination reachable (registered)
module bfs_hop_engine #(
    parameter int NODES  = 16,
    parameter int NODE_W = 4,
    parameter int COST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NODE_W-1:0] in_src,
    input  logic [NODE_W-1:0] in_dst,
    input  logic              q_valid,
    input  logic [NODE_W-1:0] q_src,
    input  logic [NODE_W-1:0] q_dst,
    output logic              q_ready,
    output logic              out_valid,
    output logic [COST_W-1:0] cost,
    output logic              found
);

    typedef enum logic [1:0] {
        READY,
        LOAD,
        SEARCH,
        DONE
    } state_t;

    state_t state, next_state;

    logic [NODES-1:0]  adj [NODES];
    logic [NODES-1:0]  frontier;
    logic [NODES-1:0]  visited;
    logic [NODES-1:0]  nxt;
    logic [COST_W-1:0] level;
    logic [NODE_W-1:0] dst_q;
    logic              beat_ok;
    logic              dst_hit;

    // A beat is stored only if both endpoints exist and it is not a self-loop.
    assign beat_ok = (int'(in_src) < NODES) && (int'(in_dst) < NODES) &&
                     (in_src != in_dst);

    // An out-of-range destination can never be matched.
    assign dst_hit = (int'(dst_q) < NODES) && frontier[dst_q];

    // Next frontier: union of the neighbours of every frontier member,
    // minus everything already visited.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        nxt = '0;
        for (int i = 0; i < NODES; i++) begin
            if (frontier[i]) nxt = nxt | adj[i];
        end
        nxt = nxt & ~visited;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state <= READY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        q_ready    = 1'b0;
        case (state)
            READY: begin
                q_ready = !in_valid;
                if (in_valid)     next_state = LOAD;
                else if (q_valid) next_state = SEARCH;
            end
            LOAD: begin
                if (!in_valid) next_state = READY;
            end
            SEARCH: begin
                if (dst_hit || frontier == '0) next_state = DONE;
            end
            DONE: begin
                next_state = READY;
            end
            default: next_state = READY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the adjacency matrix is flop-based and must come up empty,
            // so it is reset like any other state rather than left as RAM.
            for (int r = 0; r < NODES; r++) adj[r] <= '0;
            frontier  <= '0;
            visited   <= '0;
            level     <= '0;
            dst_q     <= '0;
            out_valid <= 1'b0;
            cost      <= '0;
            found     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                READY: begin
                    if (in_valid) begin
                        // New stream: wipe the old graph; the later writes
                        // below override the clear for the first beat.
                        for (int r = 0; r < NODES; r++) adj[r] <= '0;
                        if (beat_ok) begin
                            adj[in_src][in_dst] <= 1'b1;
                            adj[in_dst][in_src] <= 1'b1;
                        end
                    end else if (q_valid) begin
                        frontier <= '0;
                        visited  <= '0;
                        if (int'(q_src) < NODES) begin
                            frontier[q_src] <= 1'b1;
                            visited[q_src]  <= 1'b1;
                        end
                        level <= '0;
                        dst_q <= q_dst;
                    end
                end
                LOAD: begin
                    if (in_valid && beat_ok) begin
                        adj[in_src][in_dst] <= 1'b1;
                        adj[in_dst][in_src] <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (dst_hit) begin
                        found     <= 1'b1;
                        cost      <= level;
                        out_valid <= 1'b1;
                    end else if (frontier == '0) begin
                        found     <= 1'b0;
                        cost      <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        frontier <= nxt;
                        visited  <= visited | nxt;
                        level    <= level + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bfs_hop_engine.sv
// tb_bfs_hop_engine
//   Directed bench for bfs_hop_engine. Two instances: the default 16-station
//   build and a 40-station build. Shared stimulus is steered to one of them
//   by sel; outputs are muxed back. Expected values are hand-computed.
module tb_bfs_hop_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_src = '0;
    logic [5:0] in_dst = '0;
    logic       q_valid = 1'b0;
    logic [5:0] q_src = '0;
    logic [5:0] q_dst = '0;

    logic       q_ready_a, out_valid_a, found_a;
    logic [4:0] cost_a;
    logic       q_ready_b, out_valid_b, found_b;
    logic [5:0] cost_b;

    logic       q_ready, out_valid, found;
    logic [5:0] cost;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bfs_hop_engine #(.NODES(16), .NODE_W(4), .COST_W(5)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_src(in_src[3:0]), .in_dst(in_dst[3:0]),
        .q_valid(q_valid && !sel), .q_src(q_src[3:0]), .q_dst(q_dst[3:0]),
        .q_ready(q_ready_a), .out_valid(out_valid_a), .cost(cost_a), .found(found_a)
    );

    bfs_hop_engine #(.NODES(40), .NODE_W(6), .COST_W(6)) dut40 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_src(in_src), .in_dst(in_dst),
        .q_valid(q_valid && sel), .q_src(q_src), .q_dst(q_dst),
        .q_ready(q_ready_b), .out_valid(out_valid_b), .cost(cost_b), .found(found_b)
    );

    assign q_ready   = sel ? q_ready_b   : q_ready_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign found     = sel ? found_b     : found_a;
    assign cost      = sel ? cost_b      : {1'b0, cost_a};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_edge(input logic [5:0] a, input logic [5:0] b);
        in_valid = 1'b1;
        in_src   = a;
        in_dst   = b;
        tick();
    endtask

    // Drop in_valid and spend the closing LOAD cycle.
    task automatic end_stream();
        in_valid = 1'b0;
        tick();
    endtask

    // Issue a query and measure latency in cycles from the accept cycle T.
    task automatic do_query(input string tag, input logic [5:0] s, input logic [5:0] d,
                            input int exp_lat, input logic exp_found, input logic [5:0] exp_cost);
        int n;
        logic [5:0] c;
        q_valid = 1'b1;
        q_src   = s;
        q_dst   = d;
        #1;
        check({tag, "_qready"}, q_ready, 1'b1);
        tick();
        q_valid = 1'b0;
        n = 1;
        check({tag, "_busy"}, q_ready, 1'b0);
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_found"}, found, exp_found);
        check({tag, "_cost"}, cost, exp_cost);
        c = cost;
        tick();
        check({tag, "_ovdrop"}, out_valid, 1'b0);
        check({tag, "_hold"}, cost, c);
    endtask

    initial begin
        int ov_seen;
        tick();
        tick();
        check("rst_ov", out_valid, 1'b0);
        check("rst_cost", cost, 0);
        check("rst_found", found, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_qready", q_ready, 1'b1);

        // Chain 0-1-2-3-4
        send_edge(0, 1); send_edge(1, 2); send_edge(2, 3); send_edge(3, 4);
        end_stream();
        do_query("chain04", 0, 4, 6, 1'b1, 4);
        do_query("chain40", 4, 0, 6, 1'b1, 4);

        // Two disjoint triangles
        send_edge(0, 1); send_edge(1, 2); send_edge(2, 0);
        send_edge(5, 6); send_edge(6, 7); send_edge(7, 5);
        end_stream();
        do_query("tri06", 0, 6, 4, 1'b0, 0);
        do_query("iso99", 9, 9, 2, 1'b1, 0);

        // Redundant/duplicate edges and a self-loop
        send_edge(0, 1); send_edge(0, 1); send_edge(1, 3); send_edge(0, 2);
        send_edge(2, 3); send_edge(0, 3); send_edge(3, 3);
        end_stream();
        do_query("dup03", 0, 3, 3, 1'b1, 1);
        send_edge(0, 1); send_edge(1, 3);
        end_stream();
        do_query("reload03", 0, 3, 4, 1'b1, 2);

        // 40-station path
        sel = 1'b1;
        #1;
        for (int i = 0; i < 39; i++) send_edge(6'(i), 6'(i + 1));
        send_edge(45, 2);
        end_stream();
        do_query("p40_0_39", 0, 39, 41, 1'b1, 39);
        do_query("p40_2_45", 2, 45, 40, 1'b0, 0);
        sel = 1'b0;
        #1;

        // in_valid beats q_valid in READY
        in_valid = 1'b1; in_src = 0; in_dst = 1;
        q_valid  = 1'b1; q_src  = 0; q_dst  = 1;
        #1;
        check("prio_qready", q_ready, 1'b0);
        tick();
        in_valid = 1'b0;
        q_valid  = 1'b0;
        #1;
        check("prio_load_qready", q_ready, 1'b0);
        check("prio_ov0", out_valid, 1'b0);
        tick();
        check("prio_ov1", out_valid, 1'b0);
        do_query("prio01", 0, 1, 3, 1'b1, 1);

        // Reset during a distance-5 search
        send_edge(0, 1); send_edge(1, 2); send_edge(2, 3);
        send_edge(3, 4); send_edge(4, 5);
        end_stream();
        q_valid = 1'b1; q_src = 0; q_dst = 5;
        tick();
        q_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_ov", out_valid, 1'b0);
        check("abort_cost", cost, 0);
        check("abort_found", found, 1'b0);
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check("abort_no_ov", ov_seen, 0);
        do_query("cleared04", 0, 4, 3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
